// File: rtl/gray_conv_pkg.sv
// Shared types and helpers for the round-robin Gray-code converter arbiter.
// Holds the FSM state encoding and the requester-index width computation.
package gray_conv_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Requester index width; never below one bit so ports stay legal.
    function automatic int calc_id_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/bin2gray.sv
// Combinational binary-to-Gray converter: gray = bin ^ (bin >> 1).
module bin2gray #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one bin2gray converter among NUM_REQ requesters,
// with a single-entry result register and valid/ready handshakes on both sides.
module gray_conv_arbiter
    import gray_conv_pkg::*;
#(
    parameter  int WIDTH   = 4,
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = calc_id_w(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_bin,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    output logic [WIDTH-1:0]         rsp_gray,
    output logic [ID_W-1:0]          rsp_id,
    input  logic                     rsp_ready
);

    state_t            state_q;
    state_t            state_d;
    logic [ID_W-1:0]   ptr_q;
    logic [WIDTH-1:0]  gray_p1;
    logic [ID_W-1:0]   id_p1;

    logic              can_accept;
    logic              grant_any;
    logic              fire;
    logic [ID_W-1:0]   grant_id;
    logic [NUM_REQ-1:0] grant_oh;
    logic [WIDTH-1:0]  bin_p0;
    logic [WIDTH-1:0]  gray_p0;

    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base,
                                                 input int offset);
        int sum;
        sum = (int'(base) + offset) % NUM_REQ;
        return ID_W'(sum);
    endfunction

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] g);
        logic [ID_W-1:0] res;
        if (int'(g) == NUM_REQ - 1) begin
            res = '0;
        end else begin
            res = g + 1'b1;
        end
        return res;
    endfunction

    // ---- stage p0: arbitration and shared conversion ----
    assign can_accept = (state_q == IDLE) || rsp_ready;

    // Descending scan so the requester closest to ptr_q wins the last write.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[rr_index(ptr_q, k)]) begin
                grant_any = 1'b1;
                grant_id  = rr_index(ptr_q, k);
            end
        end
    end

    // rst_n gates the grant so no handshake can complete while in reset.
    assign fire = rst_n && can_accept && grant_any;

    always_comb begin
        grant_oh = '0;
        if (fire) begin
            grant_oh[grant_id] = 1'b1;
        end
    end

    assign req_ready = grant_oh;
    assign bin_p0    = req_bin[int'(grant_id) * WIDTH +: WIDTH];

    bin2gray #(
        .WIDTH(WIDTH)
    ) u_bin2gray (
        .bin  (bin_p0),
        .gray (gray_p0)
    );

    // ---- stage p1: result register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (rsp_ready && !fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            gray_p1 <= '0;
            id_p1   <= '0;
        end else if (fire) begin
            ptr_q   <= next_ptr(grant_id);
            gray_p1 <= gray_p0;
            id_p1   <= grant_id;
        end
    end

    assign rsp_valid = (state_q == HOLD);
    assign rsp_gray  = gray_p1;
    assign rsp_id    = id_p1;

endmodule

// File: doc/gray_conv_arbiter.md
GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
REQ-001 Parameter WIDTH, default 4: bit width of each binary request and Gray result.
REQ-002 Parameter NUM_REQ, default 4: number of requesters sharing the converter; legal range 2..16.
REQ-003 Derived constant ID_W = $clog2(NUM_REQ): requester index width.
REQ-004 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req_valid  input  NUM_REQ  per-requester request valid.
REQ-008 req_bin  input  NUM_REQ*WIDTH  packed binary operands; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 req_ready  output  NUM_REQ  one-hot-or-zero grant; a transfer on requester i occurs when req_valid[i] and req_ready[i] are both high.
REQ-010 rsp_valid  output  1  result register holds a valid result.
REQ-011 rsp_gray  output  WIDTH  Gray code of the granted operand.
REQ-012 rsp_id  output  ID_W  index of the requester that produced rsp_gray.
REQ-013 rsp_ready  input  1  downstream accepts the result when rsp_valid and rsp_ready are both high.

Function
REQ-014 Conversion SHALL be rsp_gray = b ^ (b >> 1) for granted operand b, computed by one shared converter instance; no per-requester converters.
REQ-015 FSM states: IDLE (result register empty), HOLD (result register full).
REQ-016 can_accept = (state == IDLE) || rsp_ready; req_ready SHALL be all zero when can_accept is low.
REQ-017 When can_accept is high and any req_valid is high, exactly one req_ready bit SHALL be asserted, chosen by round-robin (REQ-019); req_ready is combinational from req_valid, state, rsp_ready and the pointer.
REQ-018 req_ready SHALL never be asserted for a requester whose req_valid is low.
REQ-019 Round-robin: search starts at pointer ptr, wraps modulo NUM_REQ; after a grant to g, ptr <= (g+1) mod NUM_REQ; ptr unchanged when no grant occurs.
REQ-020 On a grant, at the next edge: rsp_gray <= gray(req_bin[g]), rsp_id <= g, state <= HOLD; latency from grant to rsp_valid is one cycle.
REQ-021 IDLE with no req_valid: stay IDLE.
REQ-022 HOLD with rsp_ready low: stay HOLD; rsp_gray, rsp_id and ptr held stable; req_ready all zero.
REQ-023 HOLD with rsp_ready high and a grant: reload the register and stay HOLD (sustained throughput of one result per cycle).
REQ-024 HOLD with rsp_ready high and no req_valid: go to IDLE; rsp_valid low next cycle.
REQ-025 rsp_valid SHALL equal (state == HOLD).
REQ-026 Pointer wrap: grant to requester NUM_REQ-1 sets ptr to 0.

Reset
REQ-027 While rst_n is low: state = IDLE, ptr = 0, rsp_gray = 0, rsp_id = 0, rsp_valid = 0, req_ready = 0, regardless of clk.
REQ-028 Reset asserted mid-HOLD SHALL discard the held result with no handshake; the first post-reset grant gives requester 0 highest priority.

Structure
REQ-029 A shared package gray_conv_pkg SHALL hold the state enum type (IDLE, HOLD) and the ID_W computation function.
REQ-030 The converter SHALL be the existing bin2gray module instantiated once with WIDTH passed through; arbitration and the FSM remain in gray_conv_arbiter.

Verification (WIDTH=4, NUM_REQ=4)
REQ-031 Single request: req_valid=0001, req_bin[0]=5 -> req_ready=0001 in the same cycle; next cycle rsp_valid=1, rsp_gray=0111, rsp_id=0.
REQ-032 All four valid, rsp_ready=1 constantly, operands 0,5,8,15 -> grants in order 0,1,2,3,0; results 0000,0111,1100,1000 on consecutive cycles.
REQ-033 Back-pressure: rsp_ready=0 for 3 cycles while in HOLD -> req_ready=0000, rsp_gray/rsp_id stable; raising rsp_ready resumes with the next round-robin grant.
REQ-034 Drain: last request consumed with req_valid=0000 and rsp_ready=1 -> rsp_valid=0 next cycle, state IDLE.
REQ-035 Reset mid-HOLD: assert rst_n=0 asynchronously between edges -> rsp_valid=0 immediately; after release, req_valid=1010 -> requester 1 is granted first.
REQ-036 Random valid/ready stress with a scoreboard: every accepted operand yields exactly one result, with the correct Gray value and rsp_id; no requester starves beyond NUM_REQ-1 intervening grants.
